ahb_input_hold_stage: RTL and testbench



---
 rtl/ahb_bm_pkg.sv | 28 ++
 rtl/ahb_input_hold_stage.sv | 107 ++++++++++
 tb/tb_ahb_input_hold_stage.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ahb_bm_pkg.sv
// Shared AHB bus-matrix definitions: HTRANS/HRESP encodings, the input-stage
// state enum and the packed address-phase record kept by the holding register.
package ahb_bm_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_HOLD = 1'b1
  } hold_state_t;

  typedef struct packed {
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        mastlock;
  } addr_phase_t;

endpackage

// File: rtl/ahb_input_hold_stage.sv
// AHB slave-port input stage: passes address phases straight through, or parks
// one in a holding register until the decoder accepts it.
// Optional macro AHB_INPUT_HOLD_AUSER_EN carries HAUSERS through the stage.
module ahb_input_hold_stage
  import ahb_bm_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELS,
  input  logic [1:0]  HTRANSS,
  input  logic [31:0] HADDRS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [2:0]  HBURSTS,
  input  logic [3:0]  HPROTS,
  input  logic        HMASTLOCKS,
  input  logic [31:0] HAUSERS,
  input  logic        HREADYS,
  input  logic        active_in,
  input  logic        readyout_in,
  input  logic [1:0]  resp_in,
  output logic        sel_in,
  output logic [1:0]  trans_in,
  output logic [31:0] addr_in,
  output logic        write_in,
  output logic [2:0]  size_in,
  output logic [2:0]  burst_in,
  output logic [3:0]  prot_in,
  output logic        mastlock_in,
  output logic [31:0] auser_in,
  output logic [21:0] decode_addr_dec,
  output logic        ready_in,
  output logic        held_tran_in,
  output logic        HREADYOUTS,
  output logic [1:0]  HRESPS
);

  hold_state_t state, state_next;
  addr_phase_t live, held, presented;
  logic        new_tran;
  logic        capture;
  logic        in_hold;

  assign live = '{trans: HTRANSS, addr: HADDRS, write: HWRITES, size: HSIZES,
                  burst: HBURSTS, prot: HPROTS, mastlock: HMASTLOCKS};

  assign new_tran = HSELS & HTRANSS[1] & HREADYS;
  assign in_hold  = (state == ST_HOLD);
  // Park only a real transfer the decoder refuses; HOLD never reloads.
  assign capture  = ~in_hold & new_tran & ~active_in;

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      ST_PASS: if (capture)   state_next = ST_HOLD;
      ST_HOLD: if (active_in) state_next = ST_PASS;
      default:                state_next = ST_PASS;
    endcase
  end

  always_ff @(posedge HCLK) begin
    // NOTE: non-blocking assignments for every flop so all state updates see pre-edge values.
    if (!HRESETn) begin
      state <= ST_PASS;
      held  <= '0;
    end else begin
      state <= state_next;
      if (capture) held <= live;
    end
  end

`ifdef AHB_INPUT_HOLD_AUSER_EN
  logic [31:0] held_auser;

  always_ff @(posedge HCLK) begin
    if (!HRESETn)     held_auser <= '0;
    else if (capture) held_auser <= HAUSERS;
  end

  assign auser_in = in_hold ? held_auser : HAUSERS;
`else
  logic unused_auser;

  assign unused_auser = ^HAUSERS;
  assign auser_in     = '0;
`endif

  assign presented = in_hold ? held : live;

  assign sel_in          = in_hold | HSELS;
  assign trans_in        = presented.trans;
  assign addr_in         = presented.addr;
  assign write_in        = presented.write;
  assign size_in         = presented.size;
  assign burst_in        = presented.burst;
  assign prot_in         = presented.prot;
  assign mastlock_in     = presented.mastlock;
  assign decode_addr_dec = presented.addr[31:10];

  // While holding, the master is stalled and the decoder sees a ready bus.
  assign held_tran_in = in_hold;
  assign ready_in     = in_hold | HREADYS;
  assign HREADYOUTS   = ~in_hold & readyout_in;
  assign HRESPS       = in_hold ? HRESP_OKAY : resp_in;

endmodule

// File: tb/tb_ahb_input_hold_stage.sv
// Self-checking bench for ahb_input_hold_stage: directed scenarios followed by
// random traffic, all compared against a transfer-level model of the stage.
module tb_ahb_input_hold_stage;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELS;
  logic [1:0]  HTRANSS;
  logic [31:0] HADDRS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HMASTLOCKS;
  logic [31:0] HAUSERS;
  logic        HREADYS;
  logic        active_in;
  logic        readyout_in;
  logic [1:0]  resp_in;
  logic        sel_in;
  logic [1:0]  trans_in;
  logic [31:0] addr_in;
  logic        write_in;
  logic [2:0]  size_in;
  logic [2:0]  burst_in;
  logic [3:0]  prot_in;
  logic        mastlock_in;
  logic [31:0] auser_in;
  logic [21:0] decode_addr_dec;
  logic        ready_in;
  logic        held_tran_in;
  logic        HREADYOUTS;
  logic [1:0]  HRESPS;

  ahb_input_hold_stage dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HTRANSS(HTRANSS),
    .HADDRS(HADDRS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HAUSERS(HAUSERS),
    .HREADYS(HREADYS), .active_in(active_in), .readyout_in(readyout_in),
    .resp_in(resp_in), .sel_in(sel_in), .trans_in(trans_in), .addr_in(addr_in),
    .write_in(write_in), .size_in(size_in), .burst_in(burst_in),
    .prot_in(prot_in), .mastlock_in(mastlock_in), .auser_in(auser_in),
    .decode_addr_dec(decode_addr_dec), .ready_in(ready_in),
    .held_tran_in(held_tran_in), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
  );

  always #5 HCLK = ~HCLK;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Model: one optional parked transfer, stored as plain variables.
  bit          m_parked;
  logic [1:0]  m_trans;
  logic [31:0] m_addr;
  logic        m_write;
  logic [2:0]  m_size;
  logic [2:0]  m_burst;
  logic [3:0]  m_prot;
  logic        m_lock;
  logic [31:0] m_auser;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic drive(input bit sel, input logic [1:0] trans, input logic [31:0] addr,
                       input bit rdy, input bit act, input bit rdo,
                       input logic [1:0] rsp, input logic [31:0] auser);
    HSELS = sel; HTRANSS = trans; HADDRS = addr; HREADYS = rdy;
    active_in = act; readyout_in = rdo; resp_in = rsp; HAUSERS = auser;
  endtask

  task automatic check_outputs();
    logic [31:0] e_addr;
    logic [31:0] e_auser;
    logic [1:0]  e_trans;
    logic [12:0] e_ctrl;
    logic [5:0]  e_stat;
    #1;
    if (m_parked) begin
      e_addr  = m_addr;
      e_trans = m_trans;
      e_ctrl  = {1'b1, m_write, m_size, m_burst, m_prot, m_lock};
      e_stat  = {1'b1, 1'b1, 1'b0, 2'b00, 1'b1};
      e_auser = m_auser;
    end else begin
      e_addr  = HADDRS;
      e_trans = HTRANSS;
      e_ctrl  = {HSELS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS};
      e_stat  = {1'b0, HREADYS, readyout_in, resp_in, 1'b0};
      e_auser = HAUSERS;
    end
`ifndef AHB_INPUT_HOLD_AUSER_EN
    e_auser = '0;
`endif
    check("addr", 64'(addr_in), 64'(e_addr));
    check("decode_addr", 64'(decode_addr_dec), 64'(e_addr >> 10));
    check("trans", 64'(trans_in), 64'(e_trans));
    check("ctrl", 64'({sel_in, write_in, size_in, burst_in, prot_in, mastlock_in}), 64'(e_ctrl));
    check("status", 64'({held_tran_in, ready_in, HREADYOUTS, HRESPS, held_tran_in}), 64'(e_stat));
    check("auser", 64'(auser_in), 64'(e_auser));
  endtask

  // Advance one clock, applying the transfer-level rules to the model.
  task automatic tick();
    @(posedge HCLK);
    if (!HRESETn) begin
      m_parked = 0;
      {m_trans, m_addr, m_write, m_size, m_burst, m_prot, m_lock, m_auser} = '0;
    end else if (m_parked) begin
      if (active_in) m_parked = 0;
    end else if (HSELS && HTRANSS[1] && HREADYS && !active_in) begin
      m_parked = 1;
      m_trans = HTRANSS; m_addr = HADDRS; m_write = HWRITES; m_size = HSIZES;
      m_burst = HBURSTS; m_prot = HPROTS; m_lock = HMASTLOCKS; m_auser = HAUSERS;
    end
    @(negedge HCLK);
  endtask

  task automatic step();
    check_outputs();
    tick();
  endtask

  initial begin
    m_parked = 0;
    HRESETn = 1'b0;
    HWRITES = 1'b1; HSIZES = 3'd2; HBURSTS = 3'd0; HPROTS = 4'h3; HMASTLOCKS = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1, 2'b00, 32'h0);
    @(negedge HCLK);
    tick();
    tick();
    step();                                    // reset asserted, state settled
    HRESETn = 1'b1;
    step();

    // Zero-latency pass-through of an accepted NONSEQ.
    drive(1'b1, 2'b10, 32'h2000_0000, 1'b1, 1'b1, 1'b1, 2'b00, 32'h11);
    step();
    check("pass_held", 64'(held_tran_in), 64'(0));
    check("pass_readyout", 64'(HREADYOUTS), 64'(1));

    // Refused NONSEQ: parks for three cycles, master scribbles meanwhile.
    HWRITES = 1'b0; HSIZES = 3'd1; HBURSTS = 3'd3; HPROTS = 4'hA; HMASTLOCKS = 1'b1;
    drive(1'b1, 2'b10, 32'h3000_0040, 1'b1, 1'b0, 1'b1, 2'b00, 32'h5A);
    step();
    drive(1'b0, 2'b11, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 2'b01, 32'hFFFF_FFFF);
    HWRITES = 1'b1; HMASTLOCKS = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("hold_addr", 64'(addr_in), 64'h3000_0040);
      check("hold_readyout", 64'(HREADYOUTS), 64'(0));
      step();
    end
    active_in = 1'b1;
    check("release_addr", 64'(addr_in), 64'h3000_0040);
    step();
    check("after_release_held", 64'(held_tran_in), 64'(0));

    // IDLE and unselected NONSEQ never park.
    drive(1'b1, 2'b00, 32'h4000_0000, 1'b1, 1'b0, 1'b1, 2'b00, 32'h0);
    step();
    check("idle_trans", 64'(trans_in), 64'(0));
    drive(1'b0, 2'b10, 32'h4000_0100, 1'b1, 1'b0, 1'b1, 2'b00, 32'h0);
    step();
    drive(1'b1, 2'b10, 32'h4000_0200, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0);
    step();
    check("no_park_held", 64'(held_tran_in), 64'(0));

    // Reset while holding.
    drive(1'b1, 2'b10, 32'h5000_0000, 1'b1, 1'b0, 1'b1, 2'b00, 32'h77);
    step();
    check("reset_pre_held", 64'(held_tran_in), 64'(1));
    HRESETn = 1'b0;
    step();
    HRESETn = 1'b1;
    drive(1'b1, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1, 2'b00, 32'h0);
    check("reset_held", 64'(held_tran_in), 64'(0));
    step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      HRESETn     = ($urandom_range(0, 99) >= 3);
      HSELS       = ($urandom_range(0, 3) != 0);
      HTRANSS     = 2'($urandom);
      HADDRS      = $urandom;
      HWRITES     = 1'($urandom);
      HSIZES      = 3'($urandom);
      HBURSTS     = 3'($urandom);
      HPROTS      = 4'($urandom);
      HMASTLOCKS  = 1'($urandom);
      HAUSERS     = $urandom;
      HREADYS     = ($urandom_range(0, 4) != 0);
      active_in   = ($urandom_range(0, 9) < 4);
      readyout_in = 1'($urandom);
      resp_in     = 2'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
